unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between two requesters: instruction fetch (IF port) and load/store (LS port).
- Sequences each access as a fixed-latency memory cycle with active-low strobes. Arbitrates contention round-robin.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Sits between the multi-cycle CPU control/datapath and the memory array; the IF and LS stages stall until their ack.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width.
MEM_LAT, 2, memory access cycles per transaction; legal range 1..15.

Ports:
CLK  input  1  clock.
Reset  input  1  asynchronous, active-high reset.
if_req  input  1  IF read request; held until if_ack.
if_addr  input  ADDR_W  IF read address.
if_rdata  output  DATA_W  IF read data; valid when if_ack=1, held until the next IF completion.
if_ack  output  1  one-cycle IF completion pulse.
ls_req  input  1  LS request; held until ls_ack.
ls_we  input  1  1=store, 0=load.
ls_addr  input  ADDR_W  LS address.
ls_wdata  input  DATA_W  store data.
ls_rdata  output  DATA_W  load data; valid when ls_ack=1, held until the next LS load completion.
ls_ack  output  1  one-cycle LS completion pulse.
mem_addr  output  ADDR_W  memory address.
mem_wdata  output  DATA_W  memory write data.
mem_rdata  input  DATA_W  memory read data.
mem_RD_n  output  1  active-low read strobe.
mem_WR_n  output  1  active-low write strobe.
busy  output  1  1 in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; if_ack=ls_ack=0; mem_RD_n=mem_WR_n=1; busy=0.
  - mem_addr, mem_wdata, if_rdata, ls_rdata, cnt = 0.
  - rr_last=LS, so IF wins the first tie.
- Reset asserted mid-transaction: the strobes deassert immediately, the transaction is abandoned, and no ack is issued.
- State IDLE:
  - Requests are sampled at the clock edge.
  - Only one requester active: it is granted.
  - Both active: the port not equal to rr_last is granted, and rr_last is updated to the granted port.
  - On grant, latch addr, we (IF forced to 0) and wdata into the registers driving mem_addr/mem_wdata; set cnt=MEM_LAT; go to ACCESS.
  - No requests: remain in IDLE with the strobes high.
- State ACCESS:
  - Read: mem_RD_n=0. Write: mem_WR_n=0. Never both low.
  - cnt decrements each cycle.
  - In the cycle with cnt==1, mem_rdata is captured (reads only) into the granted port's rdata register at the edge. State goes to RESP and both strobes go high.
  - ACCESS therefore lasts exactly MEM_LAT cycles.
- State RESP:
  - The granted port's ack=1 for exactly this cycle, then state goes to IDLE.
  - The ungranted port's ack and rdata are unchanged.
  - A store updates neither rdata register.
- Latency:
  - Request sampled at edge t → ack high during cycle t+MEM_LAT+1.
  - Minimum spacing between grants is MEM_LAT+2 cycles; one IDLE cycle always separates transactions.
- Request handling:
  - A request deasserted during ACCESS does not abort the transaction; its ack is still issued.
  - A requester must drop req on the edge ending its ack cycle; a req still high in IDLE is treated as a new request.
  - A request arriving while busy waits and is never lost, provided req stays high.
- Hold and priority:
  - Address, we and wdata changes on the inputs during ACCESS have no effect, because they are latched at grant.
  - Simultaneous new requests from both ports in IDLE are resolved by rr_last only; no fixed priority exists.
- Width: addresses and data pass through unmodified, with no alignment or masking.

Test Plan:
1. Reset release, no requests for 5 cycles → state IDLE, mem_RD_n=mem_WR_n=1, busy=0, acks 0.
2. MEM_LAT=2, memory returns 0x20010004 for address 0x00000000; if_req=1, if_addr=0x00000000 sampled at edge 0 → mem_RD_n low cycles 1–2, if_ack high in cycle 3, if_rdata=0x20010004.
3. ls_req store, ls_addr=0x00000010, ls_wdata=0xDEADBEEF → mem_WR_n low for exactly 2 cycles with mem_addr=0x10 and mem_wdata=0xDEADBEEF; ls_ack pulses once; ls_rdata unchanged.
4. if_req and ls_req rise together (after reset) → IF granted first; LS ack arrives 4 cycles after if_ack; in a second simultaneous contention, LS is granted first.
5. Reset pulse during the first ACCESS cycle of a load → mem_RD_n returns high asynchronously, no ls_ack ever issued, ls_rdata=0.
6. ls_req dropped and ls_addr changed during ACCESS → transaction completes at the original address and ls_ack still pulses once.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - round-robin arbiter sharing one fixed-latency memory between IF and LS ports
module unified_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_RD_n,
  output logic              mem_WR_n,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       gnt_ls;     // granted port of the current transaction: 1=LS, 0=IF
  logic       we_r;
  logic       rr_last;    // last tie winner: 1=LS, 0=IF
  logic       any_req;
  logic       pick_ls;

  assign any_req = if_req | ls_req;
  // On a tie the port that did not win the previous tie is chosen
  assign pick_ls = ls_req & (~if_req | ~rr_last);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  if (cnt == 4'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_RD_n = 1'b1;
    mem_WR_n = 1'b1;
    if_ack   = 1'b0;
    ls_ack   = 1'b0;
    busy     = (state != IDLE);
    case (state)
      ACCESS: begin
        mem_RD_n = we_r;
        mem_WR_n = ~we_r;
      end
      RESP: begin
        if_ack = ~gnt_ls;
        ls_ack = gnt_ls;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      cnt       <= '0;
      gnt_ls    <= 1'b0;
      we_r      <= 1'b0;
      rr_last   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          gnt_ls   <= pick_ls;
          we_r     <= pick_ls & ls_we;
          mem_addr <= pick_ls ? ls_addr : if_addr;
          if (pick_ls) mem_wdata <= ls_wdata;
          cnt      <= 4'(MEM_LAT);
          if (if_req && ls_req) rr_last <= pick_ls;
        end
        ACCESS: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1 && !we_r) begin
            if (gnt_ls) ls_rdata <= mem_rdata;
            else        if_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - directed vector bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [31:0] ls_rdata;
  logic        ls_ack;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_RD_n;
  logic        mem_WR_n;
  logic        busy;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .CLK(CLK), .Reset(Reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_ack(ls_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_RD_n(mem_RD_n), .mem_WR_n(mem_WR_n), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // 16-word memory indexed by word address bits [5:2]
  logic [31:0] mem [16];
  assign mem_rdata = mem[mem_addr[5:2]];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0101_0101 * i;
    mem[0]  = 32'h2001_0004;
    mem[1]  = 32'h1111_2222;
    mem[15] = 32'hA5A5_5A5A;
    forever begin
      @(posedge CLK);
      if (!mem_WR_n) mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  logic [31:0] exp_if_rd = '0;
  logic [31:0] exp_ls_rd = '0;

  task automatic run_txn(input vec_t v, input int idx);
    int lat = 0;
    int rd_low = 0;
    int wr_low = 0;
    int addr_bad = 0;
    bit got = 0;
    bit other_ack = 0;
    if (v.is_ls) begin
      ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      if (!mem_RD_n) rd_low++;
      if (!mem_WR_n) wr_low++;
      if ((!mem_RD_n || !mem_WR_n) && (mem_addr !== v.addr)) addr_bad++;
      if (!mem_WR_n && mem_wdata !== v.wdata) addr_bad++;
      if (v.is_ls ? if_ack : ls_ack) other_ack = 1;
      if (v.is_ls ? ls_ack : if_ack) begin
        got = 1;
        if_req = 1'b0;
        ls_req = 1'b0;
      end
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    check($sformatf("v%0d_latency", idx), lat, LAT + 1);
    check($sformatf("v%0d_rd_strobe_cycles", idx), rd_low, v.we ? 0 : LAT);
    check($sformatf("v%0d_wr_strobe_cycles", idx), wr_low, v.we ? LAT : 0);
    check($sformatf("v%0d_addr_wdata_bad", idx), addr_bad, 0);
    check($sformatf("v%0d_other_ack", idx), 32'(other_ack), 0);
    if (v.is_ls && !v.we) exp_ls_rd = v.exp_rdata;
    if (!v.is_ls) exp_if_rd = v.exp_rdata;
    check($sformatf("v%0d_if_rdata", idx), if_rdata, exp_if_rd);
    check($sformatf("v%0d_ls_rdata", idx), ls_rdata, exp_ls_rd);
    @(negedge CLK);
    check($sformatf("v%0d_idle_after", idx), {busy, if_ack, ls_ack}, 3'b000);
  endtask

  initial begin
    int if_cyc, ls_cyc, acks;
    logic saw_rd;

    vecs[0] = '{0, 0, 32'h0000_0000, 32'h0, 32'h2001_0004};
    vecs[1] = '{1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF};
    vecs[3] = '{0, 0, 32'h0000_0004, 32'h0, 32'h1111_2222};
    vecs[4] = '{1, 0, 32'hF000_003C, 32'h0, 32'hA5A5_5A5A};
    vecs[5] = '{1, 1, 32'h8000_0008, 32'h1234_5678, 32'h0};
    vecs[6] = '{0, 0, 32'h0000_0008, 32'h0, 32'h1234_5678};

    // Reset held, then released with no requests
    @(negedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("reset_idle_outputs", {busy, mem_RD_n, mem_WR_n, if_ack, ls_ack}, 5'b01100);
    end
    check("reset_rdata", {if_rdata | ls_rdata | mem_addr | mem_wdata}, 32'h0);

    // Reset pulse during first ACCESS cycle of a load
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_003C;
    @(negedge CLK);
    check("abort_rd_low_before_reset", 32'(mem_RD_n), 0);
    Reset = 1'b1;
    #1;
    check("abort_rd_high_async", {busy, mem_RD_n, mem_WR_n}, 3'b011);
    ls_req = 1'b0;
    @(negedge CLK);
    Reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (ls_ack || if_ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_ls_rdata", ls_rdata, 32'h0);

    // Single-requester vectors
    for (int i = 0; i < 7; i++) run_txn(vecs[i], i);

    // Two contention rounds: IF wins the first, LS the second
    for (int round = 0; round < 2; round++) begin
      if_req = 1'b1; if_addr = 32'h0;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_003C;
      if_cyc = -1; ls_cyc = -1;
      for (int c = 1; c <= 20 && (if_cyc < 0 || ls_cyc < 0); c++) begin
        @(negedge CLK);
        if (if_ack) begin if_cyc = c; if_req = 1'b0; end
        if (ls_ack) begin ls_cyc = c; ls_req = 1'b0; end
      end
      if_req = 1'b0; ls_req = 1'b0;
      if (round == 0) begin
        check("tie1_if_first_cycle", if_cyc, LAT + 1);
        check("tie1_ls_gap", ls_cyc - if_cyc, LAT + 2);
      end else begin
        check("tie2_ls_first_cycle", ls_cyc, LAT + 1);
        check("tie2_if_gap", if_cyc - ls_cyc, LAT + 2);
      end
      check("tie_if_rdata", if_rdata, 32'h2001_0004);
      check("tie_ls_rdata", ls_rdata, 32'hA5A5_5A5A);
      @(negedge CLK);
    end

    // LS request dropped and address changed during ACCESS
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0004;
    @(negedge CLK);
    saw_rd = ~mem_RD_n;
    check("drop_addr_held", mem_addr, 32'h0000_0004);
    ls_req = 1'b0; ls_addr = 32'h0000_0008;
    acks = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (ls_ack) acks++;
      if (!mem_RD_n && mem_addr !== 32'h0000_0004) saw_rd = 1'b0;
    end
    check("drop_rd_at_orig_addr", 32'(saw_rd), 1);
    check("drop_ack_count", acks, 1);
    check("drop_ls_rdata", ls_rdata, 32'h1111_2222);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
